// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants, parity helper.
// Common to the transmitter and the parity-checking receiver.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL = 1'b1;

   typedef enum logic [2:0] {
      s_IDLE = 3'd0,
      s_TX_START_BIT = 3'd1,
      s_TX_DATA_BITS = 3'd2,
      s_TX_PARITY = 3'd3,
      s_TX_STOP_BIT = 3'd4,
      s_CLEANUP = 3'd5
   } uart_state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Request/status bundle between a byte producer and the UART transmitter.
interface uart_tx_parity_if;

   logic i_Tx_DV;
   logic [7:0] i_Tx_Byte;
   logic o_Tx_Serial;
   logic o_Tx_Active;
   logic o_Tx_Done;

   modport master (
      output i_Tx_DV, i_Tx_Byte,
      input o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );

   modport slave (
      input i_Tx_DV, i_Tx_Byte,
      output o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks on the last cycle of each bit period.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input logic i_Clock,
   input logic i_Rst_n,
   input logic i_Clear,
   output logic o_Tick
);

   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign o_Tick = (cnt_q == LAST);

   // Restart on every bit boundary so the count never passes LAST.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (i_Clear || o_Tick) cnt_d = '0;
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, even parity, one stop bit.
module uart_tx_parity
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input logic i_Clock,
   input logic i_Rst_n,
   uart_tx_parity_if.slave tx
);

   uart_state_t state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic parity_q, parity_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] nxt_idx;
   logic serial_q, serial_d;
   logic active_q, active_d;
   logic done_q, done_d;
   logic clear;
   logic tick;

   assign clear = (state_q == s_IDLE) || (state_q == s_CLEANUP);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .i_Clock(i_Clock),
      .i_Rst_n(i_Rst_n),
      .i_Clear(clear),
      .o_Tick(tick)
   );

   // Line value is computed for the next state so it leaves a flop.
   always_comb begin
      state_d = state_q;
      byte_d = byte_q;
      parity_d = parity_q;
      idx_d = idx_q;
      nxt_idx = idx_q + 3'd1;
      serial_d = serial_q;
      active_d = active_q;
      done_d = 1'b0;
      unique case (state_q)
         s_IDLE: begin
            serial_d = STOP_LVL;
            idx_d = '0;
            if (tx.i_Tx_DV) begin
               byte_d = tx.i_Tx_Byte;
               parity_d = even_parity(tx.i_Tx_Byte);
               active_d = 1'b1;
               serial_d = START_LVL;
               state_d = s_TX_START_BIT;
            end
         end
         s_TX_START_BIT: begin
            if (tick) begin
               idx_d = '0;
               serial_d = byte_q[0];
               state_d = s_TX_DATA_BITS;
            end
         end
         s_TX_DATA_BITS: begin
            if (tick) begin
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  idx_d = '0;
                  serial_d = parity_q;
                  state_d = s_TX_PARITY;
               end else begin
                  idx_d = nxt_idx;
                  serial_d = byte_q[nxt_idx];
               end
            end
         end
         s_TX_PARITY: begin
            if (tick) begin
               serial_d = STOP_LVL;
               state_d = s_TX_STOP_BIT;
            end
         end
         s_TX_STOP_BIT: begin
            if (tick) begin
               serial_d = STOP_LVL;
               active_d = 1'b0;
               done_d = 1'b1;
               state_d = s_CLEANUP;
            end
         end
         s_CLEANUP: begin
            serial_d = STOP_LVL;
            state_d = s_IDLE;
         end
         default: begin
            serial_d = STOP_LVL;
            active_d = 1'b0;
            idx_d = '0;
            state_d = s_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= s_IDLE;
         byte_q <= '0;
         parity_q <= 1'b0;
         idx_q <= '0;
         serial_q <= STOP_LVL;
         active_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q <= byte_d;
         parity_q <= parity_d;
         idx_q <= idx_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q <= done_d;
      end
   end

   assign tx.o_Tx_Serial = serial_q;
   assign tx.o_Tx_Active = active_q;
   assign tx.o_Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Self-checking bench for uart_tx_parity with a frame-level reference model.
module tb_uart_tx_parity;

   localparam int C = 4;
   localparam int FL = 11 * C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   logic line [0:FL+1];

   always #5 clk = ~clk;

   uart_tx_parity_if tx ();

   uart_tx_parity #(
      .CLKS_PER_BIT(C)
   ) dut (
      .i_Clock(clk),
      .i_Rst_n(rst_n),
      .tx(tx)
   );

   // Frame bit n: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
   function automatic logic exp_bit(input logic [7:0] b, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (n == 0) return 1'b0;
      if (n <= 8) return b[n-1];
      if (n == 9) return logic'(ones % 2);
      return 1'b1;
   endfunction

   // One frame from request; busy_k injects a 0x55 request at cycle busy_k,
   // rst_k asserts reset at cycle rst_k and abandons the frame.
   task automatic send_frame(input logic [7:0] b, input int busy_k,
                             input int rst_k);
      logic es, ea, ed;
      @(negedge clk);
      tx.i_Tx_DV = 1'b1;
      tx.i_Tx_Byte = b;
      @(posedge clk);
      for (int k = 1; k <= FL + 1; k++) begin
         @(negedge clk);
         if (k == rst_k) begin
            tx.i_Tx_DV = 1'b0;
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (tx.o_Tx_Serial !== 1'b1 || tx.o_Tx_Active !== 1'b0 ||
                tx.o_Tx_Done !== 1'b0) begin
               n_bad++;
               $display("FAIL rst_mid ser/act/done got %b%b%b exp 100",
                        tx.o_Tx_Serial, tx.o_Tx_Active, tx.o_Tx_Done);
            end
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         es = (k <= FL) ? exp_bit(b, (k - 1) / C) : 1'b1;
         ea = (k <= FL);
         ed = (k == FL + 1);
         line[k] = tx.o_Tx_Serial;
         n_cmp++;
         if (tx.o_Tx_Serial !== es) begin
            n_bad++;
            $display("FAIL serial byte=%h k=%0d got %b exp %b",
                     b, k, tx.o_Tx_Serial, es);
         end
         n_cmp++;
         if (tx.o_Tx_Active !== ea) begin
            n_bad++;
            $display("FAIL active byte=%h k=%0d got %b exp %b",
                     b, k, tx.o_Tx_Active, ea);
         end
         n_cmp++;
         if (tx.o_Tx_Done !== ed) begin
            n_bad++;
            $display("FAIL done byte=%h k=%0d got %b exp %b",
                     b, k, tx.o_Tx_Done, ed);
         end
         tx.i_Tx_DV = (k == busy_k);
         tx.i_Tx_Byte = (k == busy_k) ? 8'h55 : 8'($urandom);
      end
   endtask

   task automatic check_idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx.i_Tx_DV = 1'b0;
         n_cmp++;
         if (tx.o_Tx_Serial !== 1'b1 || tx.o_Tx_Active !== 1'b0 ||
             tx.o_Tx_Done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s i=%0d ser/act/done got %b%b%b exp 100", tag, i,
                     tx.o_Tx_Serial, tx.o_Tx_Active, tx.o_Tx_Done);
         end
      end
   endtask

   // Receiver view: sample each bit mid-period from the captured line.
   task automatic rx_check(input logic [7:0] b);
      logic [7:0] rb;
      logic st, sp, pb, dv, perr;
      st = line[C / 2 + 1];
      for (int n = 1; n <= 8; n++) rb[n-1] = line[n * C + C / 2 + 1];
      pb = line[9 * C + C / 2 + 1];
      sp = line[10 * C + C / 2 + 1];
      dv = (st == 1'b0) && (sp == 1'b1);
      perr = (^rb) != pb;
      n_cmp++;
      if (rb !== b || dv !== 1'b1 || perr !== 1'b0) begin
         n_bad++;
         $display("FAIL loopback got byte=%h dv=%b perr=%b exp %h 1 0",
                  rb, dv, perr, b);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tx.i_Tx_DV = logic'(i % 2);
         tx.i_Tx_Byte = 8'($urandom);
         n_cmp++;
         if (tx.o_Tx_Serial !== 1'b1 || tx.o_Tx_Active !== 1'b0 ||
             tx.o_Tx_Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset i=%0d ser/act/done got %b%b%b exp 100", i,
                     tx.o_Tx_Serial, tx.o_Tx_Active, tx.o_Tx_Done);
         end
      end
      @(negedge clk);
      tx.i_Tx_DV = 1'b0;
      rst_n = 1'b1;
      check_idle(2, "post_reset");
   endtask

   task automatic test_frame_shape();
      send_frame(8'hA5, 0, 0);
      check_idle(2, "shape_idle");
   endtask

   task automatic test_parity();
      send_frame(8'h01, 0, 0);
      send_frame(8'h00, 0, 0);
      send_frame(8'hFF, 0, 0);
      check_idle(1, "parity_idle");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h3C, 0, 0);
      rx_check(8'h3C);
      send_frame(8'hC3, 0, 0);
      rx_check(8'hC3);
      check_idle(1, "b2b_idle");
   endtask

   task automatic test_busy_ignore();
      send_frame(8'hA5, 2 * C + 2, 0);
      check_idle(3 * C, "busy_data");
      send_frame(8'h5A, FL + 1, 0);
      check_idle(3 * C, "busy_cleanup");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'hA5, 0, 9 * C + 2);
      check_idle(2, "rst_release");
      send_frame(8'h12, 0, 0);
      rx_check(8'h12);
   endtask

   task automatic test_random();
      logic [7:0] b;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, 0);
         rx_check(b);
      end
   endtask

   initial begin
      tx.i_Tx_DV = 1'b0;
      tx.i_Tx_Byte = '0;
      test_reset();
      test_frame_shape();
      test_parity();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
# uart_tx_parity

- Serialises one byte per request into a UART frame on a single wire: start bit, 8 data bits LSB first, even-parity bit, one stop bit.
- Sits directly upstream of the team's parity-checking UART receiver and produces exactly the frame that receiver accepts.
- Parity is set so the receiver's check (XOR of data bits equals received parity bit) passes.
- Single clock domain; the serial line idles high.

## Interface
- CLKS_PER_BIT, 434, clock cycles per bit period. Must be ≥ 2 and must match the receiver's value.
- i_Clock  input  1  system clock; all logic on rising edge.
- i_Rst_n  input  1  reset; asynchronous and active-low (asserted at 0).
- i_Tx_DV  input  1  request strobe, 1 cycle; honoured only in s_IDLE.
- i_Tx_Byte  input  8  byte to send; sampled in the same cycle i_Tx_DV is honoured.
- o_Tx_Serial  output  1  serial line. Reset and idle value 1.
- o_Tx_Active  output  1  high while a frame is on the line. Reset value 0.
- o_Tx_Done  output  1  1-cycle pulse when a frame completes. Reset value 0.

## Operation
- States: s_IDLE, s_TX_START_BIT, s_TX_DATA_BITS, s_TX_PARITY, s_TX_STOP_BIT, s_CLEANUP, encoded 0–5. Any other encoding returns to s_IDLE.
- **s_IDLE:**
  - o_Tx_Serial=1, clock count=0, bit index=0.
  - If i_Tx_DV=1: latch i_Tx_Byte, latch parity = XOR of i_Tx_Byte, set o_Tx_Active=1, go to s_TX_START_BIT.
- **s_TX_START_BIT:** o_Tx_Serial=0 for CLKS_PER_BIT cycles, then go to s_TX_DATA_BITS with count=0.
- **s_TX_DATA_BITS:**
  - o_Tx_Serial = latched_byte[bit index], held for CLKS_PER_BIT cycles per bit.
  - Bit index increments 0→7. After bit 7 completes, index returns to 0 and the state goes to s_TX_PARITY.
- **s_TX_PARITY:** o_Tx_Serial = latched parity for CLKS_PER_BIT cycles, then go to s_TX_STOP_BIT.
- **s_TX_STOP_BIT:** o_Tx_Serial=1 for CLKS_PER_BIT cycles, then go to s_CLEANUP.
- **s_CLEANUP:** o_Tx_Serial=1, o_Tx_Done=1, o_Tx_Active=0. Next state s_IDLE, where o_Tx_Done returns to 0.
- **Requests while busy:** i_Tx_DV outside s_IDLE is ignored, including in s_CLEANUP. No queuing. Changes on i_Tx_Byte mid-frame have no effect.
- **Clock counter:**
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
  - Never wraps past CLKS_PER_BIT-1.
- **Reset mid-frame:** asynchronous return to s_IDLE. o_Tx_Serial goes high immediately; o_Tx_Active=0 and o_Tx_Done=0. The partial frame is abandoned; the receiver sees a framing fault and recovers on its own.
- **o_Tx_Serial register:** driven from a register, never combinationally from i_Tx_DV or i_Tx_Byte.

## Timing
- **Cycle numbering:** cycle 0 is the cycle in which i_Tx_DV=1 is sampled in s_IDLE.
- **Start of frame:** o_Tx_Serial falls to 0 and o_Tx_Active rises to 1 at the edge ending cycle 0. Latency is 1 cycle.
- **Bit n of the frame:** n=0 is start, 1–8 are data, 9 is parity, 10 is stop. Bit n occupies cycles 1+n·CLKS_PER_BIT through (n+1)·CLKS_PER_BIT.
- **Frame length:** 11·CLKS_PER_BIT cycles.
- **End of frame:** o_Tx_Done is high for exactly cycle 11·CLKS_PER_BIT+1, in s_CLEANUP. o_Tx_Active falls in that same cycle.
- **Back-to-back frames:** the earliest next request is sampled in cycle 11·CLKS_PER_BIT+2 (s_IDLE). This gives a stop-to-start spacing of CLKS_PER_BIT+2 high cycles, which covers the receiver's cleanup cycle.

## Structure
- **Shared package uart_pkg:**
  - State encoding constants, common to TX and RX.
  - Default CLKS_PER_BIT = 434.
  - Frame constants: DATA_BITS = 8, start level 0, stop/idle level 1.
  - Even-parity function (XOR reduce).
- **Sub-module uart_bit_timer:**
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear. Output: tick, asserted when the count reaches CLKS_PER_BIT-1.
  - Same clock and reset as the parent.
  - The receiver can reuse it later.

## Test plan
- **Frame shape:** CLKS_PER_BIT=4, reset, send 0xA5.
  - Line is 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit 4 cycles.
  - o_Tx_Active is high for 44 cycles; o_Tx_Done pulses once, at cycle 45.
- **Odd-weight parity:** send 0x01 → parity bit 1. Send 0x00 → parity bit 0. Send 0xFF → parity bit 0.
- **Loopback:** drive the receiver (CLKS_PER_BIT=4) from o_Tx_Serial, then send 0x3C followed immediately by 0xC3 at the earliest allowed cycle. Receiver must report o_Rx_Byte=0x3C then 0xC3, each with an o_Rx_DV pulse and o_Parity_Error=0.
- **Busy ignore:**
  - Pulse i_Tx_DV with 0x55 during the data bits of a 0xA5 frame → 0xA5 completes unchanged; no second frame.
  - Pulse i_Tx_DV during s_CLEANUP → ignored.
- **Reset mid-frame:** assert i_Rst_n=0 during parity bit → o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0 immediately. After release, send 0x12 → a correct frame follows.
- **Reset values:** with reset held, check o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0 while i_Tx_DV is toggled.
